// File: rtl/fsmc_buf_arbiter_if.sv
// Signal bundle between the FSMC bus / producer / buffer RAM and the buffer arbiter.
// "slave" is the arbiter's view; "master" is the surrounding system's view.
interface fsmc_buf_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 16
);
  // FSMC multiplexed bus
  logic          nadv;
  logic          noe;
  logic          nwe;
  logic [DW-1:0] ad_in;
  logic          a16;
  logic          a17;
  logic          a18;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic          finish;
  // FPGA-side producer write port
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  // Single-port buffer RAM
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  nadv, noe, nwe, ad_in, a16, a17, a18,
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output ad_out, ad_oe, finish, wr_gnt, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output nadv, noe, nwe, ad_in, a16, a17, a18,
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  ad_out, ad_oe, finish, wr_gnt, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/fsmc_buf_arbiter.sv
// Shares one single-port buffer RAM between the MCU FSMC multiplexed bus (priority)
// and an FPGA-side producer write port; all bus strobes are resynchronised into clk.
module fsmc_buf_arbiter #(
  parameter int          AW  = 15,
  parameter int          DW  = 16,
  parameter logic [3:0]  WIN = 4'b1010
) (
  input  logic             clk,
  input  logic             rst_n,
  fsmc_buf_arbiter_if.slave bus
);

  localparam int ADDR_W = DW + 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_HOLD,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t              state;
  logic                nadv_s1, nadv_s2, nadv_d;
  logic                noe_s1, noe_s2, noe_d;
  logic                nwe_s1, nwe_s2, nwe_d, nwe_d2;
  logic [DW-1:0]       ad_r;
  logic [2:0]          a_r;
  logic [ADDR_W-1:0]   addr;

  logic nadv_rise;
  logic noe_fall;
  logic nwe_start;
  logic hit;
  logic prod_ok;

  // Edges are taken on the second sync flop against a delayed copy, never on the
  // first flop, so a metastable sample can't create a spurious edge.
  assign nadv_rise = nadv_s2 & ~nadv_d;
  assign noe_fall  = ~noe_s2 & noe_d;
  // Write qualifies on exactly the second consecutive low cycle, so a write strobe
  // that began together with a read is not picked up once the read finishes.
  assign nwe_start = ~nwe_s2 & ~nwe_d & nwe_d2;
  assign hit       = (addr[ADDR_W-1 -: 4] == WIN);
  // wr_gnt is still high in the cycle the producer sees it; don't grant twice.
  assign prod_ok   = bus.wr_req & ~bus.wr_gnt;

  // NOTE: every state element below uses <= so all flops update from the same
  // pre-edge values; blocking = here would chain the sync stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      nadv_s1       <= 1'b1;
      nadv_s2       <= 1'b1;
      nadv_d        <= 1'b1;
      noe_s1        <= 1'b1;
      noe_s2        <= 1'b1;
      noe_d         <= 1'b1;
      nwe_s1        <= 1'b1;
      nwe_s2        <= 1'b1;
      nwe_d         <= 1'b1;
      nwe_d2        <= 1'b1;
      ad_r          <= '0;
      a_r           <= '0;
      addr          <= '0;
      bus.ad_out    <= '0;
      bus.ad_oe     <= 1'b0;
      bus.finish    <= 1'b0;
      bus.wr_gnt    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      nadv_s1 <= bus.nadv;
      nadv_s2 <= nadv_s1;
      nadv_d  <= nadv_s2;
      noe_s1  <= bus.noe;
      noe_s2  <= noe_s1;
      noe_d   <= noe_s2;
      nwe_s1  <= bus.nwe;
      nwe_s2  <= nwe_s1;
      nwe_d   <= nwe_s2;
      nwe_d2  <= nwe_d;
      ad_r    <= bus.ad_in;
      a_r     <= {bus.a18, bus.a17, bus.a16};

      // A new address phase may arrive mid-access; the running access keeps the
      // RAM address it already issued.
      if (nadv_rise) addr <= {a_r, ad_r};

      bus.ram_we <= 1'b0;
      bus.wr_gnt <= 1'b0;

      case (state)
        IDLE: begin
          if (noe_fall && hit) begin
            bus.ram_addr <= addr[AW-1:0];
            state        <= RD_ISSUE;
          end else if (nwe_start && noe_s2 && hit) begin
            bus.ram_addr  <= addr[AW-1:0];
            bus.ram_wdata <= ad_r;
            bus.ram_we    <= 1'b1;
            state         <= WR_WAIT;
          end else if (prod_ok) begin
            bus.ram_addr  <= bus.wr_addr;
            bus.ram_wdata <= bus.wr_data;
            bus.ram_we    <= 1'b1;
            bus.wr_gnt    <= 1'b1;
          end
        end

        RD_ISSUE: begin
          bus.ad_out <= bus.ram_rdata;
          bus.ad_oe  <= 1'b1;
          state      <= RD_HOLD;
        end

        RD_HOLD: begin
          if (noe_s2) begin
            bus.ad_oe  <= 1'b0;
            bus.finish <= ~bus.finish;
            state      <= IDLE;
          end
          if (prod_ok) begin
            bus.ram_addr  <= bus.wr_addr;
            bus.ram_wdata <= bus.wr_data;
            bus.ram_we    <= 1'b1;
            bus.wr_gnt    <= 1'b1;
          end
        end

        WR_WAIT: begin
          if (nwe_s2) state <= WR_DONE;
          if (prod_ok) begin
            bus.ram_addr  <= bus.wr_addr;
            bus.ram_wdata <= bus.wr_data;
            bus.ram_we    <= 1'b1;
            bus.wr_gnt    <= 1'b1;
          end
        end

        WR_DONE: begin
          bus.finish <= ~bus.finish;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsmc_buf_arbiter.sv
// Directed bench for fsmc_buf_arbiter: a transaction-level model (reference memory,
// expected-write queue, read window, finish parity) checked every cycle, plus literal pins.
module tb_fsmc_buf_arbiter;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fsmc_buf_arbiter_if #(.AW(15), .DW(16)) bus ();

  fsmc_buf_arbiter #(.AW(15), .DW(16), .WIN(4'b1010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Buffer RAM: write on clock, read data follows the address within the cycle.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_addr];

  int          total = 0;
  int          bad   = 0;
  wr_t         wq[$];
  logic        rd_window  = 1'b0;
  logic [15:0] rd_exp     = '0;
  logic        exp_finish = 1'b0;
  logic        settled    = 1'b0;
  logic [15:0] got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the transaction model.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.ram_we === 1'b1) begin
        if (wq.size() == 0) begin
          check("ram_we_unexpected", 32'(bus.ram_addr), 32'h7fff_ffff);
        end else begin
          e = wq.pop_front();
          check("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
          check("ram_wdata", 32'(bus.ram_wdata), 32'(e.data));
        end
      end
      if (bus.wr_gnt === 1'b1) check("gnt_with_we", 32'(bus.ram_we), 32'd1);
      if (bus.ad_oe === 1'b1) begin
        check("ad_oe_allowed", 32'(bus.ad_oe), 32'(rd_window));
        if (rd_window) check("ad_out", 32'(bus.ad_out), 32'(rd_exp));
      end
      if (settled) check("finish_idle", 32'(bus.finish), 32'(exp_finish));
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_addr(input logic [18:0] a);
    bus.nadv  = 1'b0;
    bus.ad_in = a[15:0];
    {bus.a18, bus.a17, bus.a16} = a[18:16];
    repeat (4) @(negedge clk);
    bus.nadv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic mcu_write(input logic [18:0] a, input logic [15:0] d);
    bit hit;
    hit = (a[18:15] == 4'b1010);
    settled = 1'b0;
    bus_addr(a);
    if (hit) begin
      wq.push_back(wr_t'{a[14:0], d});
      ref_mem[a[14:0]] = d;
    end
    bus.ad_in = d;
    bus.nwe   = 1'b0;
    repeat (8) @(negedge clk);
    bus.nwe = 1'b1;
    repeat (4) @(negedge clk);
    if (hit) exp_finish = ~exp_finish;
    check("finish_after_wr", 32'(bus.finish), 32'(exp_finish));
    check("wr_drained", 32'(wq.size()), 32'd0);
    repeat (2) @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic mcu_read(input logic [18:0] a, input bit req_mode, input logic [14:0] pa,
                          input logic [15:0] pd, input bit rst_mode, output logic [15:0] rd);
    bit hit, seen, granted;
    int lat;
    hit = (a[18:15] == 4'b1010);
    settled = 1'b0;
    seen = 1'b0;
    granted = 1'b0;
    lat = 0;
    rd = '0;
    bus_addr(a);
    rd_exp    = ref_mem[a[14:0]];
    rd_window = hit;
    bus.noe   = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (req_mode && n == 2) begin
        wq.push_back(wr_t'{pa, pd});
        ref_mem[pa] = pd;
        bus.wr_addr = pa;
        bus.wr_data = pd;
        bus.wr_req  = 1'b1;
      end
      if (bus.ad_oe && !seen) begin
        seen = 1'b1;
        lat  = n;
        rd   = bus.ad_out;
      end
      if (bus.wr_req && bus.wr_gnt) begin
        check("gnt_in_rd_hold", 32'(bus.ad_oe), 32'd1);
        check("gnt_cycle", 32'(n), 32'd5);
        bus.wr_req = 1'b0;
        granted = 1'b1;
      end
      if (rst_mode && n == 5) rst_n = 1'b0;
      if (rst_mode && n == 6) begin
        check("rst_oe_drop", 32'(bus.ad_oe), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        rst_n      = 1'b1;
        rd_window  = 1'b0;
        exp_finish = 1'b0;
      end
    end
    check("rd_oe_seen", 32'(seen), 32'(hit));
    if (hit) check("rd_latency", 32'(lat), 32'd4);
    if (req_mode) check("prod_granted", 32'(granted), 32'd1);
    bus.noe = 1'b1;
    repeat (2) @(negedge clk);
    if (!rst_mode) check("oe_held", 32'(bus.ad_oe), 32'(hit));
    @(negedge clk);
    check("oe_drop", 32'(bus.ad_oe), 32'd0);
    rd_window = 1'b0;
    if (hit && !rst_mode) exp_finish = ~exp_finish;
    check("finish_after_rd", 32'(bus.finish), 32'(exp_finish));
    repeat (2) @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic prod_write(input logic [14:0] pa, input logic [15:0] pd);
    bit granted;
    granted = 1'b0;
    wq.push_back(wr_t'{pa, pd});
    ref_mem[pa] = pd;
    bus.wr_addr = pa;
    bus.wr_data = pd;
    bus.wr_req  = 1'b1;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (bus.wr_gnt) granted = 1'b1;
    end
    bus.wr_req = 1'b0;
    check("prod_gnt", 32'(granted), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst_n       = 1'b0;
    bus.nadv    = 1'b1;
    bus.noe     = 1'b0;
    bus.nwe     = 1'b1;
    bus.ad_in   = '0;
    bus.a16     = 1'b0;
    bus.a17     = 1'b0;
    bus.a18     = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // T1: reset held with NOE low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_ad_oe", 32'(bus.ad_oe), 32'd0);
    check("t1_finish", 32'(bus.finish), 32'd0);
    check("t1_ram_we", 32'(bus.ram_we), 32'd0);
    check("t1_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    check("t1_ad_out", 32'(bus.ad_out), 32'd0);
    check("t1_ram_addr", 32'(bus.ram_addr), 32'd0);
    bus.noe = 1'b1;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    settled = 1'b1;

    // T2: in-window MCU write
    mcu_write(19'h50004, 16'h1234);
    check("t2_mem", 32'(mem[4]), 32'h1234);
    check("t2_finish", 32'(bus.finish), 32'd1);

    // T3: in-window MCU read
    mcu_read(19'h50004, 1'b0, 15'h0, 16'h0, 1'b0, got);
    check("t3_data", 32'(got), 32'h1234);
    check("t3_finish", 32'(bus.finish), 32'd0);

    // T4: out-of-window write and read
    mcu_write(19'h30004, 16'hDEAD);
    mcu_read(19'h30004, 1'b0, 15'h0, 16'h0, 1'b0, got);
    check("t4_mem_kept", 32'(mem[4]), 32'h1234);
    check("t4_finish", 32'(bus.finish), 32'd0);

    // T5: producer request coincides with synced NOE fall
    mcu_read(19'h50004, 1'b1, 15'h0010, 16'hBEEF, 1'b0, got);
    check("t5_data", 32'(got), 32'h1234);
    check("t5_mem", 32'(mem[16]), 32'hBEEF);
    check("t5_finish", 32'(bus.finish), 32'd1);

    // T6: producer fills top address, MCU reads it, reset strikes in RD_HOLD
    prod_write(15'h7FFF, 16'hA5A5);
    check("t6_mem", 32'(mem[32767]), 32'hA5A5);
    mcu_read(19'h57FFF, 1'b0, 15'h0, 16'h0, 1'b1, got);
    check("t6_data", 32'(got), 32'hA5A5);
    check("t6_finish", 32'(bus.finish), 32'd0);

    check("end_wq_empty", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
